dl11_multi_regs: RTL

Parameterised multi-line DL11-compatible serial register block for the pdp11 iopage, replacing single-console TT handling.
- Provides NCHAN independent lines, each with four DL11 registers (RCSR/RBUF/XCSR/XBUF), an RX FIFO of depth FIFO_DEPTH, overrun detection, and per-line RX/TX interrupts.
- Multiple lines are arbitrated onto one interrupt/vector interface.
- Connects to NCHAN external byte-level uart cores via valid/ready handshakes; baud generation lives in the uart cores.

---
 rtl/dl11_multi_regs_if.sv | 32 +++
 rtl/dl11_multi_regs.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dl11_multi_regs_if.sv
// dl11_multi_regs_if: iopage bus, interrupt and per-line uart byte streams of the DL11 block
interface dl11_multi_regs_if #(
  parameter int NCHAN = 4
);
  logic [12:0]        iopage_addr;
  logic [15:0]        data_in;
  logic [15:0]        data_out;
  logic               decode;
  logic               iopage_rd;
  logic               iopage_wr;
  logic               iopage_byte_op;
  logic               interrupt;
  logic               interrupt_ack;
  logic [7:0]         vector;
  logic [8*NCHAN-1:0] tx_data;
  logic [NCHAN-1:0]   tx_valid;
  logic [NCHAN-1:0]   tx_ready;
  logic [8*NCHAN-1:0] rx_data;
  logic [NCHAN-1:0]   rx_valid;

  modport slave (
    input  iopage_addr, data_in, iopage_rd, iopage_wr, iopage_byte_op, interrupt_ack,
           tx_ready, rx_data, rx_valid,
    output data_out, decode, interrupt, vector, tx_data, tx_valid
  );

  modport master (
    output iopage_addr, data_in, iopage_rd, iopage_wr, iopage_byte_op, interrupt_ack,
           tx_ready, rx_data, rx_valid,
    input  data_out, decode, interrupt, vector, tx_data, tx_valid
  );
endinterface

// File: rtl/dl11_multi_regs.sv
// dl11_multi_regs: NCHAN DL11 serial lines (RCSR/RBUF/XCSR/XBUF) with RX FIFOs and one arbitrated vector
module dl11_multi_regs #(
  parameter int          NCHAN      = 4,
  parameter logic [12:0] BASE_ADDR  = 13'o16500,
  parameter logic [7:0]  VEC_BASE   = 8'o300,
  parameter int          FIFO_DEPTH = 4,
  parameter int          FIFO_AW    = 2
) (
  input logic             clk,
  input logic             reset,
  dl11_multi_regs_if.slave bus
);

  logic [5:0]       off;
  logic [2:0]       line;
  logic [1:0]       rsel;
  logic             odd_byte;
  logic [7:0]       wdat;
  logic [15:0]      rword [NCHAN];
  logic [NCHAN-1:0] rx_act;
  logic [NCHAN-1:0] tx_act;
  logic             any;
  logic             sel_tx;
  logic [2:0]       sel;

  assign off      = 6'(bus.iopage_addr - BASE_ADDR);
  assign line     = off[5:3];
  assign rsel     = off[2:1];
  assign odd_byte = off[0] && bus.iopage_byte_op;
  assign wdat     = odd_byte ? bus.data_in[15:8] : bus.data_in[7:0];
  assign bus.decode = ({1'b0, bus.iopage_addr} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, bus.iopage_addr} < 14'(BASE_ADDR + 8 * NCHAN));

  always_comb begin
    bus.data_out = '0;
    for (int n = 0; n < NCHAN; n++)
      if (bus.decode && bus.iopage_rd && line == 3'(n))
        bus.data_out = odd_byte ? {8'h00, rword[n][15:8]} : rword[n];
  end

  // Scan from the highest line down so the lowest active line wins; RX overrides TX within a line
  always_comb begin
    any    = 1'b0;
    sel_tx = 1'b0;
    sel    = '0;
    for (int n = NCHAN - 1; n >= 0; n--) begin
      if (tx_act[n]) begin
        any    = 1'b1;
        sel_tx = 1'b1;
        sel    = 3'(n);
      end
      if (rx_act[n]) begin
        any    = 1'b1;
        sel_tx = 1'b0;
        sel    = 3'(n);
      end
    end
  end

  assign bus.interrupt = any;
  assign bus.vector    = any ? VEC_BASE + {2'b00, sel, sel_tx, 2'b00} : 8'h00;

  for (genvar g = 0; g < NCHAN; g++) begin : ln
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rp_q;
    logic [FIFO_AW-1:0] wp_q;
    logic [FIFO_AW:0]   cnt_q;
    logic [FIFO_AW:0]   cnt_d;
    logic [7:0]         xbuf_q;
    logic               ovr_q;
    logic               rie_q;
    logic               xie_q;
    logic               busy_q;
    logic               rx_pend_q;
    logic               tx_pend_q;
    logic               rd_q;
    logic               hit;
    logic               rd_rbuf;
    logic               rd_edge;
    logic               pop;
    logic               full;
    logic               done;
    logic               accept;
    logic               drop;
    logic               wr_rcsr;
    logic               wr_xcsr;
    logic               wr_xbuf;
    logic               ack_rx;
    logic               ack_tx;
    logic               rx_set;
    logic               tx_set;

    assign hit     = bus.decode && line == 3'(g);
    assign rd_rbuf = hit && bus.iopage_rd && rsel == 2'd1;
    assign rd_edge = rd_rbuf && !rd_q;
    assign done    = cnt_q != '0;
    assign pop     = rd_edge && done;
    assign full    = cnt_q == (FIFO_AW + 1)'(FIFO_DEPTH);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign accept  = bus.rx_valid[g] && (!full || pop);
    assign drop    = bus.rx_valid[g] && full && !pop;
    assign cnt_d   = cnt_q + (FIFO_AW + 1)'(accept) - (FIFO_AW + 1)'(pop);
    assign wr_rcsr = hit && bus.iopage_wr && rsel == 2'd0;
    assign wr_xcsr = hit && bus.iopage_wr && rsel == 2'd2;
    assign wr_xbuf = hit && bus.iopage_wr && rsel == 2'd3;
    assign ack_rx  = bus.interrupt_ack && any && !sel_tx && sel == 3'(g);
    assign ack_tx  = bus.interrupt_ack && any && sel_tx && sel == 3'(g);
    assign rx_set  = accept || (wr_rcsr && wdat[6] && !rie_q && done);
    assign tx_set  = (busy_q && bus.tx_ready[g]) || (wr_xcsr && wdat[6] && !xie_q && !busy_q);

    always_ff @(posedge clk)
      if (accept) mem_q[wp_q] <= bus.rx_data[8*g +: 8];

    always_ff @(posedge clk) begin
      if (reset) begin
        rp_q      <= '0;
        wp_q      <= '0;
        cnt_q     <= '0;
        xbuf_q    <= '0;
        ovr_q     <= 1'b0;
        rie_q     <= 1'b0;
        xie_q     <= 1'b0;
        busy_q    <= 1'b0;
        rx_pend_q <= 1'b0;
        tx_pend_q <= 1'b1;
        rd_q      <= 1'b0;
      end else begin
        rd_q      <= rd_rbuf;
        rp_q      <= rp_q + FIFO_AW'(pop);
        wp_q      <= wp_q + FIFO_AW'(accept);
        cnt_q     <= cnt_d;
        ovr_q     <= drop || (ovr_q && !rd_edge);
        rie_q     <= wr_rcsr ? wdat[6] : rie_q;
        xie_q     <= wr_xcsr ? wdat[6] : xie_q;
        xbuf_q    <= wr_xbuf ? wdat : xbuf_q;
        busy_q    <= busy_q ? !bus.tx_ready[g] : wr_xbuf;
        rx_pend_q <= rx_set || (rx_pend_q && !ack_rx);
        tx_pend_q <= tx_set || (tx_pend_q && !ack_tx);
      end
    end

    assign rword[g] = rsel == 2'd0 ? {8'h00, done, rie_q, 6'b0} :
                      rsel == 2'd1 ? {ovr_q, ovr_q, 6'b0, done ? mem_q[rp_q] : 8'h00} :
                      rsel == 2'd2 ? {8'h00, !busy_q, xie_q, 6'b0} :
                                     {8'h00, xbuf_q};
    assign rx_act[g]                = rx_pend_q && rie_q;
    assign tx_act[g]                = tx_pend_q && xie_q;
    assign bus.tx_valid[g]          = busy_q;
    assign bus.tx_data[8*g +: 8]    = xbuf_q;
  end

endmodule
